tcp_slow_send_pkt_q: RTL and testbench
======================================

# tcp_slow_send_pkt_q

Slow-path transmit queue fed by the RX pipeline's `rx_send_pkt_enq_*` interface, which carries SYN-ACK, RST and pure-ACK header-only packets. Each accepted header is checksummed over the IPv4 pseudo-header plus the 20-byte TCP header, and the checksum is inserted into the header. The completed header and its IPs are then held in a FIFO until the packet-builder stage dequeues them. The handshake is decoupled so that RX slow-path stalls reflect only this block's backpressure.

## Interface
Parameters:
- `DEPTH`, 8: FIFO entries. Power of two, ≥2.
- `PTR_W`, `$clog2(DEPTH)`: FIFO index width. Derived.

Ports:
- `clk`  in  1  sole clock; all state on rising edge
- `rst`  in  1  reset, asynchronous, active-low (0 = in reset)
- `rx_send_pkt_enq_req_val`  in  1  header offered
- `rx_send_pkt_enq_pkt`  in  `tcp_pkt_hdr`  TCP header; `chksum` field ignored
- `rx_send_pkt_enq_src_ip`  in  `IP_ADDR_W`  IPv4 source
- `rx_send_pkt_enq_dst_ip`  in  `IP_ADDR_W`  IPv4 destination
- `send_pkt_rx_enq_req_rdy`  out  1  block can accept
- `send_pkt_deq_val`  out  1  FIFO head valid
- `send_pkt_deq_pkt`  out  `tcp_pkt_hdr`  header with checksum filled
- `send_pkt_deq_src_ip`  out  `IP_ADDR_W`  head source IP
- `send_pkt_deq_dst_ip`  out  `IP_ADDR_W`  head destination IP
- `send_pkt_deq_rdy`  in  1  consumer takes head
- `send_pkt_q_occupancy`  out  `PTR_W+1`  FIFO entries in use (0..DEPTH)

## Operation
- Checksum FSM states:
  - `IDLE` → `SUM`: on enq handshake (`val && rdy`). Capture header (`chksum` forced to 0), src_ip and dst_ip. Clear the 16-bit accumulator. Clear the word index to 0.
  - `SUM`: add one 16-bit word per cycle, 16 words in order:
    - src_ip[31:16], src_ip[15:0]
    - dst_ip[31:16], dst_ip[15:0]
    - 0x0006 (protocol)
    - 0x0014 (TCP length, always 20, no options/payload)
    - 10 header words, MSB-first, `chksum` word = 0
    - After word 15 → `WRITE`.
  - Add rule: 17-bit sum, then `acc <= sum[15:0] + sum[16]` (end-around carry, same cycle). The accumulator never exceeds 16 bits.
  - `WRITE`:
    - Set `chksum = ~acc`. A result of 0x0000 is emitted as-is.
    - If FIFO not full: write the entry → `IDLE`.
    - If FIFO full: hold in `WRITE`.
- `send_pkt_rx_enq_req_rdy = (state == IDLE)`. It is combinational from the state register only and never depends on `val`.
- FIFO:
  - Show-ahead: `deq_val = !empty`; `deq_*` driven from the head entry.
  - Read and write in the same cycle are both honoured.
  - When full, a write waits for a pop registered in an earlier cycle; a same-cycle pop does not free a slot for the write.
  - Read/write pointers are `PTR_W+1` bits; the MSB is the wrap bit.
  - full = index bits equal and wrap bits differ; empty = pointers equal.
  - Occupancy = `wr_ptr - rd_ptr` (modular, `PTR_W+1` bits).
- No drops: all flow control is through `rdy`.

## Timing
- Reset (`rst`=0, asynchronous):
  - state `IDLE`, accumulator and index 0, FIFO pointers 0.
  - Outputs: `send_pkt_rx_enq_req_rdy`=1 immediately upon reset assertion (state `IDLE`), `send_pkt_deq_val`=0, `send_pkt_q_occupancy`=0, deq data don't-care.
- Reset mid-`SUM` or mid-`WRITE` discards the in-flight packet and all FIFO contents.
- Latency with FIFO not full:
  - Accept at cycle 0.
  - `SUM` cycles 1–16.
  - `WRITE` cycle 17.
  - `deq_val` high at cycle 18.
- Throughput: one packet per 18 cycles.
- `rdy` is low for cycles 1–17, and stays low while `WRITE` stalls on full.
- Dequeue: handshake when `deq_val && deq_rdy`. The head advances next cycle. Occupancy updates the cycle after each push/pop; a simultaneous push+pop leaves it unchanged.

## Structure
- `tcp_pkg`:
  - `tcp_pkt_hdr` (with `chksum` field).
  - `TCP_HDR_W` = 160.
  - `IP_PROTO_TCP` = 8'd6.
  - `TCP_HDR_BYTES` = 20.
- Sub-module `tcp_hdr_chksum_calc`: the `IDLE`/`SUM`/`WRITE` FSM with a val/rdy input and a val/rdy output. The top contains this plus the FIFO.

## Test plan
- Single SYN-ACK packet, deq_rdy=1:
  - Stimulus: src 10.0.0.1, dst 10.0.0.2, sport 0x1F90, dport 0xC000, seq 1, ack 0, off/flags 0x5012, win 0xFFFF, urg 0.
  - Response: deq_val at cycle 18, chksum 0xBC3E, IPs unchanged.
- Same packet with input chksum 0x1234: output chksum still 0xBC3E.
- deq_rdy=0, offer 10 packets:
  - Packets 1–8 fill the FIFO; occupancy reaches 8.
  - Packet 9 stalls in `WRITE`, so enq rdy stays 0 and packet 10 is not accepted.
  - One pop: packet 9 writes the cycle after the pop, with occupancy 8 again.
- Back-to-back offers with deq_rdy=1:
  - rdy pulses high once per 18 cycles.
  - Output order matches input order.
  - No packet is lost or duplicated.
- Full FIFO with simultaneous pop and pending `WRITE`:
  - Pop completes; the write follows one cycle later.
  - Occupancy goes 8→7→8.
- Assert `rst`=0 at `SUM` cycle 7 with 3 entries queued:
  - Outputs reset asynchronously: deq_val=0, occupancy=0, rdy=1.
  - After release, the next packet yields a correct checksum.

Source files
------------

// File: rtl/tcp_pkg.sv
// Shared types and constants for the TCP slow-path transmit queue.
package tcp_pkg;

    localparam int         IP_ADDR_W     = 32;
    localparam int         TCP_HDR_W     = 160;
    localparam int         TCP_HDR_BYTES = 20;
    localparam logic [7:0] IP_PROTO_TCP  = 8'd6;

    // Pseudo-header (6 words) plus TCP header (10 words)
    localparam int         CHK_IDX_W     = 4;
    localparam logic [CHK_IDX_W-1:0] CHK_LAST_IDX = 4'd15;

    typedef struct packed {
        logic [15:0] src_port;
        logic [15:0] dst_port;
        logic [31:0] seq_num;
        logic [31:0] ack_num;
        logic [15:0] off_flags;
        logic [15:0] window;
        logic [15:0] chksum;
        logic [15:0] urg_ptr;
    } tcp_pkt_hdr;

    typedef struct packed {
        tcp_pkt_hdr           pkt;
        logic [IP_ADDR_W-1:0] src_ip;
        logic [IP_ADDR_W-1:0] dst_ip;
    } send_entry_t;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_SUM   = 2'd1,
        ST_WRITE = 2'd2
    } chk_state_e;

    // One's-complement add: the carry out of bit 15 wraps back into bit 0
    function automatic logic [15:0] ones_add(input logic [15:0] a, input logic [15:0] b);
        logic [16:0] sum;
        sum = {1'b0, a} + {1'b0, b};
        return sum[15:0] + {15'd0, sum[16]};
    endfunction

endpackage

// File: rtl/tcp_hdr_chksum_calc.sv
// Captures one TCP header and computes its checksum over the IPv4
// pseudo-header and the 20-byte header, one 16-bit word per cycle.
//
//   state    | meaning
//   ---------+-----------------------------------------------------------
//   ST_IDLE  | ready for a new header
//   ST_SUM   | accumulating word idx_q (0..15) into acc_q
//   ST_WRITE | checksummed header presented downstream, waiting for rdy
module tcp_hdr_chksum_calc
    import tcp_pkg::*;
(
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_val_i,
    input  tcp_pkt_hdr           in_pkt_i,
    input  logic [IP_ADDR_W-1:0] in_src_ip_i,
    input  logic [IP_ADDR_W-1:0] in_dst_ip_i,
    output logic                 in_rdy_o,
    output logic                 out_val_o,
    output tcp_pkt_hdr           out_pkt_o,
    output logic [IP_ADDR_W-1:0] out_src_ip_o,
    output logic [IP_ADDR_W-1:0] out_dst_ip_o,
    input  logic                 out_rdy_i
);

    chk_state_e           state_q, state_d;
    logic [15:0]          acc_q;
    logic [CHK_IDX_W-1:0] idx_q;
    tcp_pkt_hdr           hdr_q;
    tcp_pkt_hdr           hdr_cap;
    logic [IP_ADDR_W-1:0] src_q;
    logic [IP_ADDR_W-1:0] dst_q;
    logic [15:0]          word;
    logic                 accept;

    assign accept = in_val_i && (state_q == ST_IDLE);

    // State register
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) state_q <= ST_IDLE;
        else      state_q <= state_d;
    end

    // Next-state logic
    always_comb begin
        state_d = state_q;
        case (state_q)
            ST_IDLE:  if (in_val_i)              state_d = ST_SUM;
            ST_SUM:   if (idx_q == CHK_LAST_IDX) state_d = ST_WRITE;
            ST_WRITE: if (out_rdy_i)             state_d = ST_IDLE;
            default:                             state_d = ST_IDLE;
        endcase
    end

    // Output logic: ready only when idle, result valid only in WRITE
    always_comb begin
        in_rdy_o         = (state_q == ST_IDLE);
        out_val_o        = (state_q == ST_WRITE);
        out_pkt_o        = hdr_q;
        out_pkt_o.chksum = ~acc_q;
        out_src_ip_o     = src_q;
        out_dst_ip_o     = dst_q;
    end

    // Incoming header with its checksum field cleared before summing
    always_comb begin
        hdr_cap        = in_pkt_i;
        hdr_cap.chksum = 16'h0000;
    end

    // Word select: pseudo-header first, then the header MSB-first
    always_comb begin
        word = 16'h0000;
        case (idx_q)
            4'd0:  word = src_q[31:16];
            4'd1:  word = src_q[15:0];
            4'd2:  word = dst_q[31:16];
            4'd3:  word = dst_q[15:0];
            4'd4:  word = {8'h00, IP_PROTO_TCP};
            4'd5:  word = 16'(TCP_HDR_BYTES);
            4'd6:  word = hdr_q.src_port;
            4'd7:  word = hdr_q.dst_port;
            4'd8:  word = hdr_q.seq_num[31:16];
            4'd9:  word = hdr_q.seq_num[15:0];
            4'd10: word = hdr_q.ack_num[31:16];
            4'd11: word = hdr_q.ack_num[15:0];
            4'd12: word = hdr_q.off_flags;
            4'd13: word = hdr_q.window;
            4'd14: word = hdr_q.chksum;
            4'd15: word = hdr_q.urg_ptr;
            default: word = 16'h0000;
        endcase
    end

    // Datapath: capture on accept, accumulate one word per SUM cycle
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            acc_q <= 16'h0000;
            idx_q <= '0;
            hdr_q <= '0;
            src_q <= '0;
            dst_q <= '0;
        end else if (accept) begin
            acc_q <= 16'h0000;
            idx_q <= '0;
            hdr_q <= hdr_cap;
            src_q <= in_src_ip_i;
            dst_q <= in_dst_ip_i;
        end else if (state_q == ST_SUM) begin
            acc_q <= ones_add(acc_q, word);
            idx_q <= idx_q + 1'b1;
        end
    end

endmodule

// File: rtl/tcp_slow_send_pkt_q.sv
// Slow-path transmit queue: checksum insertion followed by a show-ahead
// FIFO of completed headers for the packet builder.
module tcp_slow_send_pkt_q
    import tcp_pkg::*;
#(
    parameter int DEPTH = 8,
    parameter int PTR_W = $clog2(DEPTH)
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 rx_send_pkt_enq_req_val,
    input  tcp_pkt_hdr           rx_send_pkt_enq_pkt,
    input  logic [IP_ADDR_W-1:0] rx_send_pkt_enq_src_ip,
    input  logic [IP_ADDR_W-1:0] rx_send_pkt_enq_dst_ip,
    output logic                 send_pkt_rx_enq_req_rdy,
    output logic                 send_pkt_deq_val,
    output tcp_pkt_hdr           send_pkt_deq_pkt,
    output logic [IP_ADDR_W-1:0] send_pkt_deq_src_ip,
    output logic [IP_ADDR_W-1:0] send_pkt_deq_dst_ip,
    input  logic                 send_pkt_deq_rdy,
    output logic [PTR_W:0]       send_pkt_q_occupancy
);

    logic                 chk_val;
    tcp_pkt_hdr           chk_pkt;
    logic [IP_ADDR_W-1:0] chk_src_ip;
    logic [IP_ADDR_W-1:0] chk_dst_ip;

    logic [PTR_W:0]       wr_ptr_q;
    logic [PTR_W:0]       rd_ptr_q;
    send_entry_t          mem_q [DEPTH];
    send_entry_t          head;
    logic                 full;
    logic                 empty;
    logic                 push;
    logic                 pop;

    tcp_hdr_chksum_calc u_chksum (
        .clk          (clk),
        .rst          (rst),
        .in_val_i     (rx_send_pkt_enq_req_val),
        .in_pkt_i     (rx_send_pkt_enq_pkt),
        .in_src_ip_i  (rx_send_pkt_enq_src_ip),
        .in_dst_ip_i  (rx_send_pkt_enq_dst_ip),
        .in_rdy_o     (send_pkt_rx_enq_req_rdy),
        .out_val_o    (chk_val),
        .out_pkt_o    (chk_pkt),
        .out_src_ip_o (chk_src_ip),
        .out_dst_ip_o (chk_dst_ip),
        .out_rdy_i    (!full)
    );

    // Full is taken from registered pointers, so a pop in the same cycle
    // cannot make room for the pending write.
    assign full  = (wr_ptr_q[PTR_W-1:0] == rd_ptr_q[PTR_W-1:0]) &&
                   (wr_ptr_q[PTR_W] != rd_ptr_q[PTR_W]);
    assign empty = (wr_ptr_q == rd_ptr_q);
    assign push  = chk_val && !full;
    assign pop   = !empty && send_pkt_deq_rdy;

    // Pointer update; reset empties the queue
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            if (push) wr_ptr_q <= wr_ptr_q + 1'b1;
            if (pop)  rd_ptr_q <= rd_ptr_q + 1'b1;
        end
    end

    // Entry storage; contents are meaningless outside the occupied range
    always_ff @(posedge clk) begin
        if (push) mem_q[wr_ptr_q[PTR_W-1:0]] <= '{pkt: chk_pkt, src_ip: chk_src_ip, dst_ip: chk_dst_ip};
    end

    // Show-ahead head and status outputs
    always_comb begin
        head                 = mem_q[rd_ptr_q[PTR_W-1:0]];
        send_pkt_deq_val     = !empty;
        send_pkt_deq_pkt     = head.pkt;
        send_pkt_deq_src_ip  = head.src_ip;
        send_pkt_deq_dst_ip  = head.dst_ip;
        send_pkt_q_occupancy = wr_ptr_q - rd_ptr_q;
    end

endmodule

// File: tb/tb_tcp_slow_send_pkt_q.sv
module tb_tcp_slow_send_pkt_q;
    import tcp_pkg::*;

    localparam int DEPTH = 8;

    logic        clk = 1'b0;
    logic        rst;
    logic        val;
    tcp_pkt_hdr  pkt;
    logic [31:0] src_ip, dst_ip;
    logic        rdy;
    logic        deq_val;
    tcp_pkt_hdr  deq_pkt;
    logic [31:0] deq_src, deq_dst;
    logic        deq_rdy;
    logic [3:0]  occ;

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    tcp_slow_send_pkt_q #(.DEPTH(DEPTH)) dut (
        .clk                     (clk),
        .rst                     (rst),
        .rx_send_pkt_enq_req_val (val),
        .rx_send_pkt_enq_pkt     (pkt),
        .rx_send_pkt_enq_src_ip  (src_ip),
        .rx_send_pkt_enq_dst_ip  (dst_ip),
        .send_pkt_rx_enq_req_rdy (rdy),
        .send_pkt_deq_val        (deq_val),
        .send_pkt_deq_pkt        (deq_pkt),
        .send_pkt_deq_src_ip     (deq_src),
        .send_pkt_deq_dst_ip     (deq_dst),
        .send_pkt_deq_rdy        (deq_rdy),
        .send_pkt_q_occupancy    (occ)
    );

    typedef struct {
        tcp_pkt_hdr  hdr;
        logic [31:0] src;
        logic [31:0] dst;
        logic [15:0] ck;
        int          lat;
    } vec_t;

    int checks = 0;
    int errors = 0;
    vec_t exp_q[$];

    task automatic chk(input string name, input logic [159:0] act, input logic [159:0] req);
        checks++;
        if (act !== req) begin
            errors++;
            $display("FAIL %s actual=%0h required=%0h", name, act, req);
        end
    endtask

    // Internet checksum from its definition: plain integer sum of all words,
    // folded afterwards, then complemented.
    function automatic logic [15:0] ref_ck(input tcp_pkt_hdr h, input logic [31:0] s, input logic [31:0] d);
        logic [159:0] bits;
        int unsigned  sum;
        tcp_pkt_hdr   z;
        z = h;
        z.chksum = 16'h0;
        bits = z;
        sum = s[31:16] + s[15:0] + d[31:16] + d[15:0] + 32'd6 + 32'd20;
        for (int i = 0; i < 10; i++) sum += bits[16*i +: 16];
        while (sum > 32'hFFFF) sum = (sum & 32'hFFFF) + (sum >> 16);
        return ~sum[15:0];
    endfunction

    function automatic vec_t rand_vec();
        vec_t v;
        v.hdr = {$urandom, $urandom, $urandom, $urandom, $urandom};
        v.src = $urandom;
        v.dst = $urandom;
        v.ck  = ref_ck(v.hdr, v.src, v.dst);
        v.lat = 18;
        return v;
    endfunction

    function automatic vec_t seq_vec(input int n);
        vec_t v;
        v = rand_vec();
        v.hdr.seq_num = n;
        v.ck = ref_ck(v.hdr, v.src, v.dst);
        return v;
    endfunction

    // Offer one header; returns the cycle whose closing edge takes it
    task automatic offer(input vec_t v, output int acc_cyc, output bit ok);
        ok = 1'b0;
        acc_cyc = -1;
        @(negedge clk);
        pkt = v.hdr; src_ip = v.src; dst_ip = v.dst; val = 1'b1;
        for (int n = 0; n < 60; n++) begin
            if (rdy) begin
                ok = 1'b1;
                acc_cyc = cyc;
                exp_q.push_back(v);
                break;
            end
            @(negedge clk);
        end
        if (ok) @(negedge clk);
        val = 1'b0;
        if (!ok) chk("accept_timeout", 0, 1);
    endtask

    task automatic wait_deq_val(output int at_cyc);
        at_cyc = -1;
        for (int n = 0; n < 60; n++) begin
            @(negedge clk);
            if (deq_val) begin
                at_cyc = cyc;
                break;
            end
        end
        if (at_cyc < 0) chk("deq_val_timeout", 0, 1);
    endtask

    // Compare the FIFO head with the oldest expected entry and retire it
    task automatic check_head(input string tag);
        vec_t       v;
        tcp_pkt_hdr eh;
        if (exp_q.size() == 0) begin
            chk({tag, "_unexpected_pkt"}, 1, 0);
            return;
        end
        v = exp_q.pop_front();
        eh = v.hdr;
        eh.chksum = v.ck;
        chk({tag, "_chksum"}, deq_pkt.chksum, v.ck);
        chk({tag, "_hdr"},    deq_pkt, eh);
        chk({tag, "_src"},    deq_src, v.src);
        chk({tag, "_dst"},    deq_dst, v.dst);
    endtask

    task automatic drain(input string tag, input int budget);
        for (int n = 0; n < budget; n++) begin
            @(negedge clk);
            deq_rdy = 1'b1;
            if (exp_q.size() == 0) break;
            if (deq_val) check_head(tag);
        end
        chk({tag, "_drain_left"}, exp_q.size(), 0);
    endtask

    vec_t tbl[5];
    vec_t syn;

    initial begin
        int   acc, at, rdy_hi;
        int   acc_b[4];
        bit   ok;
        vec_t cur, p10;
        bit   pend;
        int   n_acc;

        rst = 1'b0; val = 1'b0; pkt = '0; src_ip = '0; dst_ip = '0; deq_rdy = 1'b0;

        syn.hdr = '{src_port: 16'h1F90, dst_port: 16'hC000, seq_num: 32'd1, ack_num: 32'd0,
                    off_flags: 16'h5012, window: 16'hFFFF, chksum: 16'h0, urg_ptr: 16'h0};
        syn.src = 32'h0A00_0001;
        syn.dst = 32'h0A00_0002;
        syn.ck  = 16'hBC3E;
        syn.lat = 18;

        tbl[0] = syn;
        tbl[1] = syn;
        tbl[1].hdr.chksum = 16'h1234;
        tbl[2].hdr = '{src_port: 16'h0050, dst_port: 16'hD431, seq_num: 32'h1234_5678, ack_num: 32'd0,
                       off_flags: 16'h5014, window: 16'h0, chksum: 16'h0, urg_ptr: 16'h0};
        tbl[2].src = 32'hC0A8_0164;
        tbl[2].dst = 32'hC0A8_0101;
        tbl[2].ck  = ref_ck(tbl[2].hdr, tbl[2].src, tbl[2].dst);
        tbl[2].lat = 18;
        tbl[3].hdr = '1;
        tbl[3].src = 32'hFFFF_FFFF;
        tbl[3].dst = 32'hFFFF_FFFF;
        tbl[3].ck  = 16'hFFE5;
        tbl[3].lat = 18;
        tbl[4].hdr = '0;
        tbl[4].src = 32'h0;
        tbl[4].dst = 32'h0;
        tbl[4].ck  = 16'hFFE5;
        tbl[4].lat = 18;

        // Reset state
        #12;
        chk("rst_rdy", rdy, 1);
        chk("rst_deq_val", deq_val, 0);
        chk("rst_occ", occ, 0);
        @(negedge clk);
        rst = 1'b1;

        // Table vectors, one at a time, consumer always ready
        deq_rdy = 1'b1;
        foreach (tbl[i]) begin
            offer(tbl[i], acc, ok);
            wait_deq_val(at);
            chk($sformatf("tbl%0d_latency", i), at - acc, tbl[i].lat);
            check_head($sformatf("tbl%0d", i));
            @(negedge clk);
            chk($sformatf("tbl%0d_occ_after_pop", i), occ, 0);
        end

        // Back-to-back offers: acceptance spacing and in-order delivery
        fork
            begin
                for (int i = 0; i < 4; i++) offer(seq_vec(100 + i), acc_b[i], ok);
            end
            begin
                int got = 0;
                for (int n = 0; n < 200 && got < 4; n++) begin
                    @(negedge clk);
                    if (deq_val) begin
                        check_head($sformatf("b2b%0d", got));
                        got++;
                    end
                end
                chk("b2b_count", got, 4);
            end
        join
        for (int i = 0; i < 3; i++) chk($sformatf("b2b_spacing%0d", i), acc_b[i+1] - acc_b[i], 18);

        // Fill the FIFO with the consumer stalled
        @(negedge clk);
        deq_rdy = 1'b0;
        for (int i = 0; i < 8; i++) offer(seq_vec(200 + i), acc, ok);
        repeat (18) @(negedge clk);
        chk("full_occ8", occ, 8);
        chk("full_deq_val", deq_val, 1);
        offer(seq_vec(208), acc, ok);
        repeat (20) @(negedge clk);
        chk("stall_rdy_low", rdy, 0);
        chk("stall_occ8", occ, 8);
        p10 = seq_vec(209);
        pkt = p10.hdr; src_ip = p10.src; dst_ip = p10.dst; val = 1'b1;
        rdy_hi = 0;
        for (int n = 0; n < 30; n++) begin
            @(negedge clk);
            if (rdy) rdy_hi++;
        end
        chk("pkt10_not_accepted", rdy_hi, 0);
        check_head("full_pop");
        deq_rdy = 1'b1;
        @(negedge clk);
        deq_rdy = 1'b0;
        chk("pop_occ7", occ, 7);
        chk("pop_rdy_still_low", rdy, 0);
        @(negedge clk);
        chk("write_after_pop_occ8", occ, 8);
        chk("write_after_pop_rdy", rdy, 1);
        if (rdy) exp_q.push_back(p10);
        @(negedge clk);
        val = 1'b0;
        drain("full_drain", 400);
        @(negedge clk);
        chk("full_drain_occ0", occ, 0);

        // Asynchronous reset in the middle of a checksum with entries queued
        deq_rdy = 1'b0;
        for (int i = 0; i < 3; i++) offer(seq_vec(300 + i), acc, ok);
        repeat (18) @(negedge clk);
        chk("pre_rst_occ3", occ, 3);
        offer(seq_vec(303), acc, ok);
        while (cyc < acc + 7) @(negedge clk);
        #1 rst = 1'b0;
        #1;
        chk("midrst_rdy", rdy, 1);
        chk("midrst_deq_val", deq_val, 0);
        chk("midrst_occ", occ, 0);
        exp_q.delete();
        repeat (2) @(negedge clk);
        rst = 1'b1;
        deq_rdy = 1'b1;
        offer(syn, acc, ok);
        wait_deq_val(at);
        chk("post_rst_latency", at - acc, 18);
        check_head("post_rst");

        // Randomized traffic against the scoreboard
        pend = 1'b0;
        n_acc = 0;
        for (int n = 0; n < 3000 && n_acc < 25; n++) begin
            @(negedge clk);
            if (!pend && $urandom_range(0, 1) == 1) begin
                cur = rand_vec();
                pend = 1'b1;
            end
            val = pend;
            pkt = cur.hdr; src_ip = cur.src; dst_ip = cur.dst;
            deq_rdy = ($urandom_range(0, 3) != 0);
            if (deq_val && deq_rdy) check_head("rnd");
            if (pend && rdy) begin
                exp_q.push_back(cur);
                pend = 1'b0;
                n_acc++;
            end
        end
        chk("rnd_accepted", n_acc, 25);
        @(negedge clk);
        val = 1'b0;
        drain("rnd_drain", 600);
        @(negedge clk);
        chk("rnd_final_deq_val", deq_val, 0);
        chk("rnd_final_occ", occ, 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
